// File: rtl/ddr_rd_arbiter.sv
// Round-robin read-address arbiter for one DDR read channel. Beats are returned in order via a
// tag FIFO. Define DDR_RD_ARB_PRIO_EN to give requester 0 strict priority over the RR group.
module ddr_rd_arbiter #(
  parameter int unsigned REQ_NUM     = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BURST_W     = 8,
  parameter int unsigned DDR_W       = 512,
  parameter int unsigned OUTSTANDING = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_NUM*ADDR_W-1:0]  req_addr,
  input  logic [REQ_NUM*BURST_W-1:0] req_size,
  input  logic [REQ_NUM-1:0]         req_valid,
  output logic [REQ_NUM-1:0]         req_ready,
  output logic [DDR_W-1:0]           rsp_data,
  output logic [REQ_NUM-1:0]         rsp_valid,
  output logic                       rsp_last,
  input  logic [REQ_NUM-1:0]         rsp_ready,
  output logic [ADDR_W-1:0]          ddr_addr,
  output logic [BURST_W-1:0]         ddr_size,
  output logic                       ddr_addr_valid,
  input  logic                       ddr_addr_ready,
  input  logic [DDR_W-1:0]           ddr_data,
  input  logic                       ddr_valid,
  output logic                       ddr_ready,
  output logic                       busy,
  output logic                       orphan_err
);

  localparam int unsigned IdW  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int unsigned PtrW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]     win_id;
  logic               win_found;
  int                 idx;
  logic [ADDR_W-1:0]  win_addr;
  logic [BURST_W-1:0] win_size;

  logic [IdW-1:0]     tag_id_q   [OUTSTANDING];
  logic [BURST_W-1:0] tag_size_q [OUTSTANDING];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
  logic               orphan_q;

  logic               fifo_empty, fifo_full, slot_free, has_room;
  logic               grant, beat_acc, last_beat, pop;
  logic [IdW-1:0]     head_id;
  logic [BURST_W-1:0] head_size;

  // Winner scan starting at the RR pointer, wrapping modulo REQ_NUM.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < int'(REQ_NUM); k++) begin
      idx = (int'(rr_ptr_q) + k) % int'(REQ_NUM);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = IdW'(idx);
      end
    end
`ifdef DDR_RD_ARB_PRIO_EN
    if (req_valid[0]) begin
      win_found = 1'b1;
      win_id    = '0;
    end
`endif
  end

  assign win_addr = req_addr[int'(win_id)*ADDR_W +: ADDR_W];
  assign win_size = req_size[int'(win_id)*BURST_W +: BURST_W];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(OUTSTANDING));
  assign head_id    = tag_id_q[rd_ptr_q];
  assign head_size  = tag_size_q[rd_ptr_q];

  assign ddr_ready = !fifo_empty && rsp_ready[head_id];
  assign beat_acc  = ddr_valid && ddr_ready;
  assign last_beat = !fifo_empty && (beat_cnt_q == head_size);
  assign pop       = beat_acc && last_beat;

  assign slot_free = !ddr_addr_valid || ddr_addr_ready;
  // A completing burst frees its tag slot in the same cycle, so a full FIFO can still accept.
  assign has_room  = !fifo_full || pop;
  assign grant     = !rst && slot_free && has_room && win_found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (ddr_valid && !fifo_empty) rsp_valid[head_id] = 1'b1;
  end

  assign rsp_data   = ddr_data;
  assign rsp_last   = last_beat;
  assign busy       = ddr_addr_valid || !fifo_empty;
  assign orphan_err = orphan_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (win_id == IdW'(REQ_NUM - 1)) ? '0 : win_id + IdW'(1);
`ifdef DDR_RD_ARB_PRIO_EN
      if (win_id == '0) rr_ptr_d = rr_ptr_q;
`endif
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({grant, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (beat_acc) beat_cnt_d = last_beat ? '0 : beat_cnt_q + BURST_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      beat_cnt_q     <= '0;
      orphan_q       <= 1'b0;
      ddr_addr_valid <= 1'b0;
      ddr_addr       <= '0;
      ddr_size       <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      count_q    <= count_d;
      beat_cnt_q <= beat_cnt_d;
      if (grant) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (ddr_valid && fifo_empty) orphan_q <= 1'b1;
      if (grant) begin
        ddr_addr_valid <= 1'b1;
        ddr_addr       <= win_addr;
        ddr_size       <= win_size;
      end else if (ddr_addr_ready) begin
        ddr_addr_valid <= 1'b0;
      end
    end
  end

  // Tag storage needs no reset: entries are only read while the FIFO count says they are valid.
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_id_q[wr_ptr_q]   <= win_id;
      tag_size_q[wr_ptr_q] <= win_size;
    end
  end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed vector bench for ddr_rd_arbiter: a per-cycle table plus hand-written sequences
// for FIFO-full and (when DDR_RD_ARB_PRIO_EN is defined) requester-0 priority.
module tb_ddr_rd_arbiter;

  localparam int unsigned ReqNum = 4;
  localparam int unsigned AddrW  = 32;
  localparam int unsigned BurstW = 8;
  localparam int unsigned DdrW   = 32;
  localparam int unsigned Outst  = 8;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [ReqNum*AddrW-1:0]   req_addr;
  logic [ReqNum*BurstW-1:0]  req_size;
  logic [ReqNum-1:0]         req_valid = '0;
  logic [ReqNum-1:0]         req_ready;
  logic [DdrW-1:0]           rsp_data;
  logic [ReqNum-1:0]         rsp_valid;
  logic                      rsp_last;
  logic [ReqNum-1:0]         rsp_ready = '0;
  logic [AddrW-1:0]          ddr_addr;
  logic [BurstW-1:0]         ddr_size;
  logic                      ddr_addr_valid;
  logic                      ddr_addr_ready = 1'b0;
  logic [DdrW-1:0]           ddr_data = '0;
  logic                      ddr_valid = 1'b0;
  logic                      ddr_ready;
  logic                      busy;
  logic                      orphan_err;

  always #5 clk = ~clk;

  ddr_rd_arbiter #(
    .REQ_NUM    (ReqNum),
    .ADDR_W     (AddrW),
    .BURST_W    (BurstW),
    .DDR_W      (DdrW),
    .OUTSTANDING(Outst)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_addr      (req_addr),
    .req_size      (req_size),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .rsp_data      (rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_last      (rsp_last),
    .rsp_ready     (rsp_ready),
    .ddr_addr      (ddr_addr),
    .ddr_size      (ddr_size),
    .ddr_addr_valid(ddr_addr_valid),
    .ddr_addr_ready(ddr_addr_ready),
    .ddr_data      (ddr_data),
    .ddr_valid     (ddr_valid),
    .ddr_ready     (ddr_ready),
    .busy          (busy),
    .orphan_err    (orphan_err)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  rv;
    logic [3:0]  rr;
    logic        ar;
    logic        dv;
    logic [3:0]  e_rq;
    logic        e_av;
    logic [31:0] e_addr;
    logic [7:0]  e_size;
    logic [3:0]  e_rv;
    logic        e_last;
    logic        e_dr;
    logic        e_busy;
    logic        e_orph;
  } vec_t;

  localparam int NVec = 42;
  vec_t vecs [NVec];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] rv, input logic [3:0] rr,
                              input logic ar, input logic dv, input logic [3:0] erq,
                              input logic eav, input logic [31:0] ea, input logic [7:0] es,
                              input logic [3:0] erv, input logic el, input logic edr,
                              input logic eb, input logic eo);
    vec_t v;
    v = '{r, rv, rr, ar, dv, erq, eav, ea, es, erv, el, edr, eb, eo};
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic [3:0] rv, input logic [3:0] rr,
                       input logic ar, input logic dv, input logic [31:0] d);
    @(negedge clk);
    rst            = r;
    req_valid      = rv;
    rsp_ready      = rr;
    ddr_addr_ready = ar;
    ddr_valid      = dv;
    ddr_data       = d;
    #1;
  endtask

  initial begin
    logic [127:0] act, exp;
    for (int i = 0; i < int'(ReqNum); i++) begin
      req_addr[i*AddrW +: AddrW] = 32'h1000 + 32'h100 * i;
    end
    req_size = {8'd0, 8'd2, 8'd1, 8'd3};

    // Single burst, orphan beat, round robin, address backpressure, drain with stall, reset.
    vecs[0]  = mk(1, 4'b0001, 4'b1111, 1, 0, 4'b0000, 0, 32'h0,    8'd0, 4'b0000, 0, 0, 0, 0);
    vecs[1]  = mk(0, 4'b0001, 4'b1111, 1, 0, 4'b0001, 0, 32'h0,    8'd0, 4'b0000, 0, 0, 0, 0);
    vecs[2]  = mk(0, 4'b0000, 4'b1111, 1, 0, 4'b0000, 1, 32'h1000, 8'd3, 4'b0000, 0, 1, 1, 0);
    vecs[3]  = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1000, 8'd3, 4'b0001, 0, 1, 1, 0);
    vecs[4]  = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1000, 8'd3, 4'b0001, 0, 1, 1, 0);
    vecs[5]  = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1000, 8'd3, 4'b0001, 0, 1, 1, 0);
    vecs[6]  = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1000, 8'd3, 4'b0001, 1, 1, 1, 0);
    vecs[7]  = mk(0, 4'b0000, 4'b1111, 1, 0, 4'b0000, 0, 32'h1000, 8'd3, 4'b0000, 0, 0, 0, 0);
    vecs[8]  = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1000, 8'd3, 4'b0000, 0, 0, 0, 0);
    vecs[9]  = mk(0, 4'b0000, 4'b1111, 1, 0, 4'b0000, 0, 32'h1000, 8'd3, 4'b0000, 0, 0, 0, 1);
    vecs[10] = mk(1, 4'b0000, 4'b1111, 1, 0, 4'b0000, 0, 32'h0,    8'd0, 4'b0000, 0, 0, 0, 0);
    vecs[11] = mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0001, 0, 32'h0,    8'd0, 4'b0000, 0, 0, 0, 0);
    vecs[12] = mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0010, 1, 32'h1000, 8'd3, 4'b0000, 0, 1, 1, 0);
    vecs[13] = mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0100, 1, 32'h1100, 8'd1, 4'b0000, 0, 1, 1, 0);
    vecs[14] = mk(0, 4'b1111, 4'b1111, 1, 0, 4'b1000, 1, 32'h1200, 8'd2, 4'b0000, 0, 1, 1, 0);
    vecs[15] = mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0001, 1, 32'h1300, 8'd0, 4'b0000, 0, 1, 1, 0);
    vecs[16] = mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0010, 1, 32'h1000, 8'd3, 4'b0000, 0, 1, 1, 0);
    vecs[17] = mk(0, 4'b0000, 4'b1111, 0, 0, 4'b0000, 1, 32'h1100, 8'd1, 4'b0000, 0, 1, 1, 0);
    for (int i = 18; i <= 22; i++) begin
      vecs[i] = mk(0, 4'b0010, 4'b1111, 0, 0, 4'b0000, 1, 32'h1100, 8'd1, 4'b0000, 0, 1, 1, 0);
    end
    vecs[23] = mk(0, 4'b0010, 4'b1111, 1, 0, 4'b0010, 1, 32'h1100, 8'd1, 4'b0000, 0, 1, 1, 0);
    vecs[24] = mk(0, 4'b0000, 4'b1111, 1, 0, 4'b0000, 1, 32'h1100, 8'd1, 4'b0000, 0, 1, 1, 0);
    vecs[25] = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1100, 8'd1, 4'b0001, 0, 1, 1, 0);
    vecs[26] = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1100, 8'd1, 4'b0001, 0, 1, 1, 0);
    vecs[27] = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1100, 8'd1, 4'b0001, 0, 1, 1, 0);
    vecs[28] = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1100, 8'd1, 4'b0001, 1, 1, 1, 0);
    vecs[29] = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1100, 8'd1, 4'b0010, 0, 1, 1, 0);
    vecs[30] = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1100, 8'd1, 4'b0010, 1, 1, 1, 0);
    vecs[31] = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1100, 8'd1, 4'b0100, 0, 1, 1, 0);
    vecs[32] = mk(0, 4'b0000, 4'b1011, 1, 1, 4'b0000, 0, 32'h1100, 8'd1, 4'b0100, 0, 0, 1, 0);
    vecs[33] = mk(0, 4'b0000, 4'b1011, 1, 1, 4'b0000, 0, 32'h1100, 8'd1, 4'b0100, 0, 0, 1, 0);
    vecs[34] = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1100, 8'd1, 4'b0100, 0, 1, 1, 0);
    vecs[35] = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1100, 8'd1, 4'b0100, 1, 1, 1, 0);
    vecs[36] = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1100, 8'd1, 4'b1000, 1, 1, 1, 0);
    vecs[37] = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1100, 8'd1, 4'b0001, 0, 1, 1, 0);
    vecs[38] = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h1100, 8'd1, 4'b0001, 0, 1, 1, 0);
    vecs[39] = mk(1, 4'b1111, 4'b1111, 1, 1, 4'b0000, 0, 32'h0,    8'd0, 4'b0000, 0, 0, 0, 0);
    vecs[40] = mk(0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 32'h0,    8'd0, 4'b0000, 0, 0, 0, 0);
    vecs[41] = mk(0, 4'b0000, 4'b1111, 1, 0, 4'b0000, 0, 32'h0,    8'd0, 4'b0000, 0, 0, 0, 1);

`ifndef DDR_RD_ARB_PRIO_EN
    for (int i = 0; i < NVec; i++) begin
      logic [31:0] d;
      d = 32'hD000_0000 + 32'(i);
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rr, vecs[i].ar, vecs[i].dv, d);
      act = {43'd0, req_ready, ddr_addr_valid, ddr_addr, ddr_size, rsp_valid, rsp_last,
             ddr_ready, busy, orphan_err, rsp_data};
      exp = {43'd0, vecs[i].e_rq, vecs[i].e_av, vecs[i].e_addr, vecs[i].e_size, vecs[i].e_rv,
             vecs[i].e_last, vecs[i].e_dr, vecs[i].e_busy, vecs[i].e_orph, d};
      check($sformatf("vec%0d", i), act, exp);
    end
`endif

    // FIFO full: eight grants with no data, ninth blocked, then pop+push keeps it full.
    drive(1, 4'b0000, 4'b1111, 1, 0, 32'h0);
    for (int k = 0; k < int'(Outst); k++) begin
      drive(0, 4'b0001, 4'b1111, 1, 0, 32'h0);
      check($sformatf("full_grant%0d", k), 128'(req_ready), 128'(4'b0001));
    end
    drive(0, 4'b0001, 4'b1111, 1, 0, 32'h0);
    check("full_block", 128'(req_ready), 128'(4'b0000));
    for (int k = 0; k < 3; k++) begin
      drive(0, 4'b0001, 4'b0001, 1, 1, 32'hBEEF);
      check($sformatf("full_beat%0d", k), 128'({req_ready, rsp_valid, rsp_last}),
            128'({4'b0000, 4'b0001, 1'b0}));
    end
    drive(0, 4'b0001, 4'b0001, 1, 1, 32'hBEEF);
    check("full_pop_push", 128'({req_ready, rsp_valid, rsp_last}),
          128'({4'b0001, 4'b0001, 1'b1}));
    drive(0, 4'b0001, 4'b0001, 1, 0, 32'h0);
    check("full_still", 128'({req_ready, busy}), 128'({4'b0000, 1'b1}));

`ifdef DDR_RD_ARB_PRIO_EN
    drive(1, 4'b0000, 4'b1111, 1, 0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 4'b0101, 4'b1111, 1, 0, 32'h0);
      check($sformatf("prio_req0_%0d", k), 128'(req_ready), 128'(4'b0001));
    end
    drive(0, 4'b0100, 4'b1111, 1, 0, 32'h0);
    check("prio_req2", 128'(req_ready), 128'(4'b0100));
    drive(0, 4'b0110, 4'b1111, 1, 0, 32'h0);
    check("prio_rr_req1", 128'(req_ready), 128'(4'b0010));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
